// File: rtl/mem_port_arbiter_if.sv
// Bus bundle tying the datapath's instruction/data memory ports and the shared memory port
// to the arbiter. The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if;
  logic        instr_read;
  logic [31:0] instr_mem_address;
  logic [31:0] instr_mem_rdata;
  logic        instr_mem_resp;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_mem_address;
  logic [31:0] data_mem_wdata;
  logic [3:0]  data_mbe;
  logic [31:0] data_mem_rdata;
  logic        data_mem_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mbe;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport slave (
    input  instr_read, instr_mem_address, data_read, data_write,
           data_mem_address, data_mem_wdata, data_mbe, mem_rdata, mem_resp,
    output instr_mem_rdata, instr_mem_resp, data_mem_rdata, data_mem_resp,
           mem_read, mem_write, mem_address, mem_wdata, mem_mbe
  );

  modport master (
    output instr_read, instr_mem_address, data_read, data_write,
           data_mem_address, data_mem_wdata, data_mbe, mem_rdata, mem_resp,
    input  instr_mem_rdata, instr_mem_resp, data_mem_rdata, data_mem_resp,
           mem_read, mem_write, mem_address, mem_wdata, mem_mbe
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serializes the datapath's data and instruction ports onto one memory port (data first) and
// releases both responses together in a single RESP cycle.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE_D, ISSUE_I, RESP} state_t;

  state_t      state, state_next;
  logic        pend_i, pend_d, op_write;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_mbe;
  logic [31:0] ibuf, dbuf, ibuf_next, dbuf_next;
  logic [31:0] wd_cnt;
  logic        req_i, req_d, req_write;
  logic [31:0] req_i_addr, req_d_addr, req_d_wdata;
  logic [3:0]  req_d_mbe;
  logic        in_issue, next_issue, issue_entry;

  // While IDLE the live inputs are the request; afterwards only the latched copy counts.
  always_comb begin
    req_i       = pend_i;
    req_d       = pend_d;
    req_write   = op_write;
    req_i_addr  = i_addr;
    req_d_addr  = d_addr;
    req_d_wdata = d_wdata;
    req_d_mbe   = d_mbe;
    if (state == IDLE) begin
      req_i       = bus.instr_read;
      req_d       = bus.data_read | bus.data_write;
      req_write   = bus.data_write;
      req_i_addr  = bus.instr_mem_address;
      req_d_addr  = bus.data_mem_address;
      req_d_wdata = bus.data_mem_wdata;
      req_d_mbe   = bus.data_mbe;
    end
  end

  always_comb begin
    state_next = state;
    ibuf_next  = ibuf;
    dbuf_next  = dbuf;
    case (state)
      IDLE: begin
        if (req_d)      state_next = ISSUE_D;
        else if (req_i) state_next = ISSUE_I;
      end
      ISSUE_D: begin
        if (bus.mem_resp) begin
          dbuf_next  = op_write ? 32'h0 : bus.mem_rdata;
          state_next = pend_i ? ISSUE_I : RESP;
        end
      end
      ISSUE_I: begin
        if (bus.mem_resp) begin
          ibuf_next  = bus.mem_rdata;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_issue    = (state == ISSUE_D) || (state == ISSUE_I);
  assign next_issue  = (state_next == ISSUE_D) || (state_next == ISSUE_I);
  assign issue_entry = next_issue && (state_next != state);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_i              <= 1'b0;
      pend_d              <= 1'b0;
      op_write            <= 1'b0;
      i_addr              <= 32'h0;
      d_addr              <= 32'h0;
      d_wdata             <= 32'h0;
      d_mbe               <= 4'h0;
      ibuf                <= 32'h0;
      dbuf                <= 32'h0;
      bus.mem_read        <= 1'b0;
      bus.mem_write       <= 1'b0;
      bus.mem_address     <= 32'h0;
      bus.mem_wdata       <= 32'h0;
      bus.mem_mbe         <= 4'h0;
      bus.instr_mem_resp  <= 1'b0;
      bus.data_mem_resp   <= 1'b0;
      bus.instr_mem_rdata <= 32'h0;
      bus.data_mem_rdata  <= 32'h0;
    end else begin
      if (state == IDLE) begin
        pend_i   <= req_i;
        pend_d   <= req_d;
        op_write <= req_write;
        i_addr   <= req_i_addr;
        d_addr   <= req_d_addr;
        d_wdata  <= req_d_wdata;
        d_mbe    <= req_d_mbe;
      end
      ibuf <= ibuf_next;
      dbuf <= dbuf_next;

      // The memory request is loaded on entry to each ISSUE state and dropped on leaving them.
      if (issue_entry && state_next == ISSUE_D) begin
        bus.mem_read    <= !req_write;
        bus.mem_write   <= req_write;
        bus.mem_address <= req_d_addr;
        bus.mem_wdata   <= req_d_wdata;
        bus.mem_mbe     <= req_write ? req_d_mbe : 4'hF;
      end else if (issue_entry && state_next == ISSUE_I) begin
        bus.mem_read    <= 1'b1;
        bus.mem_write   <= 1'b0;
        bus.mem_address <= req_i_addr;
        bus.mem_mbe     <= 4'hF;
      end else if (!next_issue) begin
        bus.mem_read  <= 1'b0;
        bus.mem_write <= 1'b0;
      end

      bus.instr_mem_resp <= (state_next == RESP) && pend_i;
      bus.data_mem_resp  <= (state_next == RESP) && pend_d;
      if (state_next == RESP) begin
        bus.instr_mem_rdata <= ibuf_next;
        bus.data_mem_rdata  <= dbuf_next;
      end
    end
  end

  // Watchdog counts completed cycles of the current ISSUE state; the flag is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt      <= 32'h0;
      timeout_err <= 1'b0;
    end else begin
      if (issue_entry)
        wd_cnt <= 32'h0;
      else if (in_issue && wd_cnt != 32'hFFFF_FFFF)
        wd_cnt <= wd_cnt + 32'h1;
      if (TIMEOUT_CYCLES != 0 && in_issue && wd_cnt >= TIMEOUT_CYCLES - 1)
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of request vectors, a latency-programmable memory model
// that checks each access in order, and a scoreboard matched against the paired responses.
module tb_mem_port_arbiter;
  localparam int TO = 8;
  localparam int NV = 9;

  typedef struct {
    bit          ir, dr, dw;
    logic [31:0] ia, da, wd;
    logic [3:0]  mbe;
    int          lat;
    bit          exp_iresp, exp_dresp;
    logic [31:0] exp_irdata, exp_drdata;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
    logic [3:0]  mbe;
  } acc_t;

  typedef struct {
    bit          iresp, dresp;
    logic [31:0] irdata, drdata;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic timeout_err;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mem_lat = 0;
  bit   hang = 1'b0;
  bit   spurious = 1'b0;
  bit   mdl_active = 1'b0;
  int   mdl_left = 0;
  vec_t tbl [NV];
  acc_t exp_acc [$];
  exp_t sb [$];
  logic [31:0] mem_img [logic [31:0]];

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {16'hBAD0, a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_access();
    acc_t e;
    if (exp_acc.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_access: addr %h rd %0b wr %0b", bus.mem_address, bus.mem_read, bus.mem_write);
    end else begin
      e = exp_acc.pop_front();
      checkOutput("acc_addr", bus.mem_address, e.addr);
      checkOutput("acc_write", 32'(bus.mem_write), 32'(e.wr));
      checkOutput("acc_read", 32'(bus.mem_read), 32'(!e.wr));
      checkOutput("acc_mbe", 32'(bus.mem_mbe), 32'(e.mbe));
      if (e.wr) checkOutput("acc_wdata", bus.mem_wdata, e.wdata);
    end
  endtask

  // Memory model: a new access starts on the first request cycle after the previous reply.
  initial begin
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mdl_active   = 1'b0;
        bus.mem_resp = 1'b0;
      end else begin
        if (bus.mem_resp) begin
          bus.mem_resp = 1'b0;
          mdl_active   = 1'b0;
        end
        if (spurious) begin
          spurious      = 1'b0;
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = 32'hFFFF_FFFF;
        end else begin
          if (!mdl_active && (bus.mem_read || bus.mem_write)) begin
            mdl_active = 1'b1;
            mdl_left   = mem_lat;
            check_access();
          end
          if (mdl_active && !hang) begin
            if (mdl_left == 0) begin
              bus.mem_resp  = 1'b1;
              bus.mem_rdata = bus.mem_write ? 32'h0BAD_0BAD : mem_val(bus.mem_address);
            end else begin
              mdl_left--;
            end
          end
        end
      end
    end
  end

  // Response monitor: every resp cycle must match the oldest scoreboard entry.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst && (bus.instr_mem_resp || bus.data_mem_resp)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_resp: iresp %0b dresp %0b", bus.instr_mem_resp, bus.data_mem_resp);
      end else begin
        e = sb.pop_front();
        checkOutput("instr_resp", 32'(bus.instr_mem_resp), 32'(e.iresp));
        checkOutput("data_resp", 32'(bus.data_mem_resp), 32'(e.dresp));
        checkOutput("instr_rdata", bus.instr_mem_rdata, e.irdata);
        checkOutput("data_rdata", bus.data_mem_rdata, e.drdata);
        checkOutput("resp_cycle", cyc, e.due);
      end
    end
  end

  task automatic idle_inputs();
    bus.instr_read        = 1'b0;
    bus.instr_mem_address = 32'h0;
    bus.data_read         = 1'b0;
    bus.data_write        = 1'b0;
    bus.data_mem_address  = 32'h0;
    bus.data_mem_wdata    = 32'h0;
    bus.data_mbe          = 4'h0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int n_acc = 0;
    @(negedge clk);
    mem_lat               = v.lat;
    bus.instr_read        = v.ir;
    bus.instr_mem_address = v.ia;
    bus.data_read         = v.dr;
    bus.data_write        = v.dw;
    bus.data_mem_address  = v.da;
    bus.data_mem_wdata    = v.wd;
    bus.data_mbe          = v.mbe;
    if (v.dr || v.dw) begin
      exp_acc.push_back('{v.da, v.dw, v.wd, v.dw ? v.mbe : 4'hF});
      n_acc++;
    end
    if (v.ir) begin
      exp_acc.push_back('{v.ia, 1'b0, 32'h0, 4'hF});
      n_acc++;
    end
    sb.push_back('{v.exp_iresp, v.exp_dresp, v.exp_irdata, v.exp_drdata, cyc + 1 + n_acc * (v.lat + 1)});
    // Inputs move after the sample; the arbiter must keep working on the latched request.
    @(negedge clk);
    bus.instr_read        = ~v.ir;
    bus.data_read         = ~v.dr;
    bus.data_write        = ~v.dw;
    bus.instr_mem_address = v.ia ^ 32'hFFFF_0000;
    bus.data_mem_address  = v.da ^ 32'hFFFF_0000;
    bus.data_mem_wdata    = ~v.wd;
    bus.data_mbe          = ~v.mbe;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((sb.size() != 0 || exp_acc.size() != 0) && n < bound) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (sb.size() != 0 || exp_acc.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d resps and %0d accesses outstanding", sb.size(), exp_acc.size());
      sb.delete();
      exp_acc.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_mem_read"}, 32'(bus.mem_read), 32'h0);
    checkOutput({tag, "_mem_write"}, 32'(bus.mem_write), 32'h0);
    checkOutput({tag, "_mem_address"}, bus.mem_address, 32'h0);
    checkOutput({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    checkOutput({tag, "_mem_mbe"}, 32'(bus.mem_mbe), 32'h0);
    checkOutput({tag, "_instr_resp"}, 32'(bus.instr_mem_resp), 32'h0);
    checkOutput({tag, "_data_resp"}, 32'(bus.data_mem_resp), 32'h0);
    checkOutput({tag, "_instr_rdata"}, bus.instr_mem_rdata, 32'h0);
    checkOutput({tag, "_data_rdata"}, bus.data_mem_rdata, 32'h0);
    checkOutput({tag, "_timeout"}, 32'(timeout_err), 32'h0);
  endtask

  initial begin
    int t0;
    mem_img[32'h60]   = 32'h00A00093;
    mem_img[32'h64]   = 32'h00000013;
    mem_img[32'h68]   = 32'h00000513;
    mem_img[32'h6C]   = 32'h00100073;
    mem_img[32'h1000] = 32'hDEADBEEF;
    mem_img[32'h3000] = 32'h12345678;

    //           ir dr dw ia        da          wd            mbe      lat iresp dresp irdata        drdata
    tbl[0] = '{1, 0, 0, 32'h60, 32'h0,    32'h0,         4'h0,    3,  1, 0, 32'h00A00093, 32'h0};
    tbl[1] = '{1, 1, 0, 32'h64, 32'h1000, 32'h0,         4'h0,    1,  1, 1, 32'h00000013, 32'hDEADBEEF};
    tbl[2] = '{1, 0, 1, 32'h68, 32'h2004, 32'h0000AB00,  4'b0010, 2,  1, 1, 32'h00000513, 32'h0};
    tbl[3] = '{0, 1, 0, 32'h0,  32'h3000, 32'h0,         4'h0,    0,  0, 1, 32'h00000513, 32'h12345678};
    tbl[4] = '{0, 1, 1, 32'h0,  32'h4000, 32'hCAFEF00D,  4'hF,    0,  0, 1, 32'h00000513, 32'h0};
    tbl[5] = '{1, 0, 0, 32'h6C, 32'h0,    32'h0,         4'h0,    0,  1, 0, 32'h00100073, 32'h0};
    tbl[6] = '{1, 1, 0, 32'h60, 32'h3000, 32'h0,         4'h0,    0,  1, 1, 32'h00A00093, 32'h12345678};
    tbl[7] = '{0, 0, 1, 32'h0,  32'h5000, 32'hFF000000,  4'b1000, 4,  0, 1, 32'h00A00093, 32'h0};
    tbl[8] = '{1, 0, 0, 32'h64, 32'h0,    32'h0,         4'h0,    5,  1, 0, 32'h00000013, 32'h0};

    idle_inputs();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;

    // Reset in the middle of a data access that memory never answers.
    hang = 1'b1;
    @(negedge clk);
    bus.data_read        = 1'b1;
    bus.data_mem_address = 32'h1000;
    exp_acc.push_back('{32'h1000, 1'b0, 32'h0, 4'hF});
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    checkOutput("t1_mem_read", 32'(bus.mem_read), 32'h1);
    checkOutput("t1_mem_address", bus.mem_address, 32'h1000);
    #2;
    rst = 1'b0;
    mdl_active = 1'b0;
    #1;
    check_reset_outputs("t1");
    sb.delete();
    exp_acc.delete();
    @(negedge clk);
    rst = 1'b1;
    hang = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t1_idle_read", 32'(bus.mem_read), 32'h0);
    checkOutput("t1_idle_write", 32'(bus.mem_write), 32'h0);

    for (int k = 0; k < NV; k++) begin
      applyStimulus(tbl[k]);
      wait_drain(40);
      idle_inputs();
      repeat (2) @(negedge clk);
      checkOutput("hold_instr_rdata", bus.instr_mem_rdata, tbl[k].exp_irdata);
      checkOutput("hold_data_rdata", bus.data_mem_rdata, tbl[k].exp_drdata);
    end
    checkOutput("no_timeout", 32'(timeout_err), 32'h0);

    // A stray memory reply while IDLE must not start or complete anything.
    @(negedge clk);
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("stray_mem_read", 32'(bus.mem_read), 32'h0);
    checkOutput("stray_instr_rdata", bus.instr_mem_rdata, 32'h00000013);
    applyStimulus(tbl[5]);
    wait_drain(40);
    idle_inputs();

    // Watchdog: memory stops answering a fetch.
    hang = 1'b1;
    mem_lat = 0;
    @(negedge clk);
    bus.instr_read        = 1'b1;
    bus.instr_mem_address = 32'h70;
    exp_acc.push_back('{32'h70, 1'b0, 32'h0, 4'hF});
    t0 = cyc;
    @(negedge clk);
    idle_inputs();
    while (cyc < t0 + TO) @(negedge clk);
    checkOutput("t6_before", 32'(timeout_err), 32'h0);
    @(negedge clk);
    checkOutput("t6_rise", 32'(timeout_err), 32'h1);
    repeat (10) @(negedge clk);
    checkOutput("t6_sticky", 32'(timeout_err), 32'h1);
    checkOutput("t6_still_waiting", 32'(bus.mem_read), 32'h1);
    checkOutput("t6_access_seen", exp_acc.size(), 32'h0);
    #2;
    rst = 1'b0;
    mdl_active = 1'b0;
    #1;
    checkOutput("t6_reset_clears", 32'(timeout_err), 32'h0);
    exp_acc.delete();
    @(negedge clk);
    rst = 1'b1;
    hang = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: bench did not complete");
    $fatal(1, "[TB] aborted");
  end

endmodule
